hd_top: RTL
===========

Name: hd_top

Overview:
Pipelined Hamming single-error-correcting decoder, the receive-side counterpart of the Hamming encoder (he_top). It accepts k+m-bit codewords with a valid strobe. It computes the m-bit syndrome, corrects any single-bit error, and delivers the k data bits two cycles later. It also raises per-word error flags and keeps a saturating corrected-error counter for the decoder simenv (hd_simenv) and for system status.

Parameters:
- k, 11, number of data bits per codeword.
- m, 4, number of parity bits. Must be the smallest m with 2^m >= k+m+1, the same value the encoder derives via get_m(k); the simenv sets it by defparam.
- CW, 16, width of the corrected-error counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cin  input  k+m  received codeword; cin[i-1] holds Hamming position i.
- cvld  input  1  cin valid this cycle; no backpressure.
- cnt_clr  input  1  synchronous clear of cor_cnt.
- dout  output  k  decoded/corrected data.
- dvld  output  1  dout valid; single-cycle pulse per accepted word.
- err_cor  output  1  with dvld: single error found and corrected (data or parity bit).
- err_unc  output  1  with dvld: syndrome > k+m, so uncorrectable; data passed uncorrected.
- syndrome  output  m  syndrome of the word presented with dvld.
- cor_cnt  output  CW  count of words with err_cor=1, saturating.

Behaviour:
- Codeword layout, identical to the encoder:
  - Positions 1..n, with n = k+m.
  - Parity bit p_j sits at position 2^j, for j = 0..m-1.
  - Data bits fill the non-power-of-two positions in ascending order; din[0] goes to the lowest such position.
  - p_j = XOR of all positions whose index has bit j set (even parity).
- Syndrome: bit j = XOR of cin positions with index bit j set, parity position included. syndrome=0 means no error.
- Pipeline, fixed latency of 2 cycles from cvld to dvld:
  - Stage 1: register cin and cvld, and compute the syndrome combinationally from the registered word.
  - Stage 2: register the corrected data, dvld, flags and syndrome.
  - Full throughput: a word on every cycle is legal; bubbles pass through as dvld=0.
- Correction:
  - If 1 <= syndrome <= n, invert position `syndrome`, then extract data. err_cor=1, err_unc=0.
  - If syndrome > n (possible only when n < 2^m-1), no correction. err_unc=1, err_cor=0.
  - If syndrome = 0, both flags are 0.
- Output hold rules:
  - dout and syndrome hold their last values while dvld=0.
  - err_cor and err_unc are forced to 0 whenever dvld=0.
- Counter:
  - cor_cnt increments by 1 in the cycle dvld&err_cor is registered.
  - Saturates at 2^CW-1 and never wraps.
  - cnt_clr=1 loads 0 and takes priority over a coincident increment.
- Reset values: dout=0, dvld=0, err_cor=0, err_unc=0, syndrome=0, cor_cnt=0.
- Reset mid-operation: all in-flight words are discarded; no dvld pulse for them after rst deasserts. The first word accepted after deassertion appears 2 cycles later.
- Multi-bit errors are out of scope (SEC only). A double error yields a miscorrection or err_unc; no further detection is required.

Test Plan (k=11, m=4, n=15):
- Reset, then cin=15'h0000 with cvld -> 2 cycles later dout=11'h000, dvld=1, syndrome=0, err_cor=0, cor_cnt=0.
- cin=15'h7FFF (data 11'h7FF, all parity 1) -> dout=11'h7FF, syndrome=0, no flags.
- cin=15'h7FEF (position 5 flipped) -> dout=11'h7FF, syndrome=5, err_cor=1, cor_cnt=1. Then cin=15'h7FFE (parity position 1 flipped) -> dout=11'h7FF, syndrome=1, err_cor=1, cor_cnt=2.
- Back-to-back stream of 16 words, each a single-bit flip of 15'h7FFF at positions 1..15 plus one clean word -> 16 consecutive dvld pulses in order, all dout=11'h7FF, cor_cnt=15. Repeat with cvld gaps -> gaps preserved at output.
- cnt_clr asserted in the same cycle as an err_cor increment -> cor_cnt=0 next cycle. Force cor_cnt to 16'hFFFF, then one more error -> stays 16'hFFFF.
- rst asserted while two words are in flight -> no dvld for them. Outputs go to reset values immediately (asynchronously), before the next clock edge.
- Loopback through he_top for random data over all 2^11 values with random single-bit injection -> dout equals original data on every word.

Source files
------------

// File: rtl/hd_top.sv
// hd_top: pipelined Hamming single-error-correcting decoder.
// Two-cycle latency from cvld to dvld, one word per cycle, no backpressure.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   cin      - received codeword, cin[i-1] is Hamming position i
//   cvld     - cin valid this cycle
//   cnt_clr  - synchronous clear of cor_cnt (wins over an increment)
//   dout     - corrected data, holds while dvld=0
//   dvld     - one-cycle pulse per accepted word
//   err_cor  - single error corrected (qualified by dvld)
//   err_unc  - syndrome points past the codeword (qualified by dvld)
//   syndrome - syndrome of the word shown with dvld, holds while dvld=0
//   cor_cnt  - saturating count of corrected words
module hd_top #(
   parameter int unsigned k  = 11,
   parameter int unsigned m  = 4,
   parameter int unsigned CW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [k+m-1:0]  cin,
   input  logic            cvld,
   input  logic            cnt_clr,
   output logic [k-1:0]    dout,
   output logic            dvld,
   output logic            err_cor,
   output logic            err_unc,
   output logic [m-1:0]    syndrome,
   output logic [CW-1:0]   cor_cnt
);

   localparam int unsigned N  = k + m;
   localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned KW = (k > 1) ? $clog2(k) : 1;
   localparam int unsigned MW = (m > 1) ? $clog2(m) : 1;

   // stage 1 registers
   logic [N-1:0]  cw_q;
   logic          vld_q;

   // stage 2 registers
   logic [k-1:0]  dout_q,  dout_d;
   logic          dvld_q,  dvld_d;
   logic          cor_q,   cor_d;
   logic          unc_q,   unc_d;
   logic [m-1:0]  syn_q,   syn_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   // combinational decode of the stage-1 word
   logic [m-1:0]  syn_c;
   logic          hit_c;
   logic          unc_c;
   logic [N-1:0]  fix_c;
   logic [k-1:0]  data_c;
   int unsigned   didx;

   // Syndrome bit j is the parity over every position whose index has bit j set.
   always_comb begin
      syn_c = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         for (int unsigned j = 0; j < m; j++) begin
            if (((i >> j) & 32'd1) != 32'd0) begin
               syn_c[MW'(j)] = syn_c[MW'(j)] ^ cw_q[NW'(i - 1)];
            end
         end
      end
   end

   // A syndrome above n names a position that does not exist in this code.
   always_comb begin
      hit_c = (syn_c != '0) && (32'(syn_c) <= N);
      unc_c = (32'(syn_c) > N);
   end

   // Flip the addressed position, then gather data from non-power-of-two slots.
   always_comb begin
      fix_c  = cw_q;
      data_c = '0;
      didx   = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         if (hit_c && (32'(syn_c) == i)) begin
            fix_c[NW'(i - 1)] = ~cw_q[NW'(i - 1)];
         end
      end
      for (int unsigned i = 1; i <= N; i++) begin
         if ((i & (i - 1)) != 32'd0) begin
            data_c[KW'(didx)] = fix_c[NW'(i - 1)];
            didx              = didx + 1;
         end
      end
   end

   // Stage-2 next state; flags are qualified by valid, data/syndrome hold.
   always_comb begin
      dvld_d = vld_q;
      dout_d = dout_q;
      syn_d  = syn_q;
      cor_d  = vld_q & hit_c;
      unc_d  = vld_q & unc_c;
      cnt_d  = cnt_q;
      if (vld_q) begin
         dout_d = data_c;
         syn_d  = syn_c;
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (cor_d && (cnt_q != {CW{1'b1}})) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Pipeline registers; reset drops every word in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cw_q   <= '0;
         vld_q  <= 1'b0;
         dout_q <= '0;
         dvld_q <= 1'b0;
         cor_q  <= 1'b0;
         unc_q  <= 1'b0;
         syn_q  <= '0;
         cnt_q  <= '0;
      end else begin
         cw_q   <= cin;
         vld_q  <= cvld;
         dout_q <= dout_d;
         dvld_q <= dvld_d;
         cor_q  <= cor_d;
         unc_q  <= unc_d;
         syn_q  <= syn_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout     = dout_q;
   assign dvld     = dvld_q;
   assign err_cor  = cor_q;
   assign err_unc  = unc_q;
   assign syndrome = syn_q;
   assign cor_cnt  = cnt_q;

endmodule
